mem_interface: RTL

- Multicycle memory controller between the CPU datapath's MAR/MDR pair and the synchronous word RAM.
- Takes Read/write strobes from the control unit and latches the address and store data.
- Inserts a configurable number of wait states, then performs one RAM access.
- Returns load data to the MDR's Mdatain, plus a done pulse the control unit uses to leave its memory-wait step.

---
 rtl/mem_if_pkg.sv | 24 ++
 rtl/mem_wait_counter.sv | 30 +++
 rtl/mem_interface.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the multicycle memory interface: state and
// operation encodings plus the default geometry of the word RAM.
package mem_if_pkg;

  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 32;
  localparam int MAX_WAIT   = 15;

  // Width of the wait-state counter; must be able to hold MAX_WAIT.
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } memState_e;

  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } memOp_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times the WAIT state. The terminal-count
// flag is raised while the count sits at 1, i.e. in the last wait cycle,
// so the FSM can leave WAIT on that cycle.
module mem_wait_counter
  import mem_if_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WAIT_CNT_W-1:0] loadVal,
  input  logic                  en,
  output logic                  tc
);

  logic [WAIT_CNT_W-1:0] count;

  // Load on request acceptance, otherwise count down while enabled; stop at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (en && (count != '0)) begin
      count <= count - WAIT_CNT_W'(1);
    end
  end

  assign tc = (count == WAIT_CNT_W'(1));

endmodule

// File: rtl/mem_interface.sv
// Multicycle memory controller between the MAR/MDR pair and a synchronous
// word RAM. A rising edge on Read or write (while idle) latches the address
// and store data, waits WAIT_STATES cycles, performs one RAM access and
// pulses done; load data is returned on rdata and held afterwards.
module mem_interface
  import mem_if_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int WAIT_STATES = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT) begin : gWaitRange
    $error("mem_interface: WAIT_STATES must lie in 0..15");
  end

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_WAIT   = WAIT;
  localparam logic [1:0] S_ACCESS = ACCESS;
  localparam logic [1:0] S_DONE   = DONE;

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);
  localparam bit                    HAS_WAIT  = (WAIT_STATES > 0);

  logic [1:0]        state;
  logic              readPrev;
  logic              writePrev;
  logic              readRise;
  logic              writeRise;
  logic              bothRise;
  logic              accept;
  memOp_e            op;
  logic [ADDR_W-1:0] addrLatch;
  logic [DATA_W-1:0] dataLatch;
  logic [DATA_W-1:0] holdReg;
  logic              errReg;
  logic              waitTc;

  // Requests are edges against the previous-cycle levels, so a level held
  // through done never re-triggers. Simultaneous edges are rejected.
  assign readRise  = Read  & ~readPrev;
  assign writeRise = write & ~writePrev;
  assign bothRise  = readRise & writeRise;
  assign accept    = (state == S_IDLE) && (readRise ^ writeRise);

  // Registered copies of the request levels, updated in every state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      readPrev  <= 1'b0;
      writePrev <= 1'b0;
    end else begin
      readPrev  <= Read;
      writePrev <= write;
    end
  end

  // One-cycle error pulse when both request lines rise together.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      errReg <= 1'b0;
    end else begin
      errReg <= bothRise;
    end
  end

  // Wait-state timer, loaded with WAIT_STATES when a request is accepted.
  mem_wait_counter uWaitCnt (
    .clk     (Clock),
    .rst     (Reset),
    .load    (accept),
    .loadVal (WAIT_INIT),
    .en      (state == S_WAIT),
    .tc      (waitTc)
  );

  // Access sequencer: IDLE -> [WAIT x WAIT_STATES] -> ACCESS -> DONE -> IDLE.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= HAS_WAIT ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          if (waitTc) begin
            state <= S_ACCESS;
          end
        end
        S_ACCESS: state <= S_DONE;
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Address, store data and operation are captured once per accepted request
  // and drive the RAM pins directly until the next request replaces them.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      addrLatch <= '0;
      dataLatch <= '0;
      op        <= LOAD;
    end else if (accept) begin
      addrLatch <= addr;
      dataLatch <= wdata;
      op        <= writeRise ? STORE : LOAD;
    end
  end

  // Load result hold register; the RAM output is only valid in DONE.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      holdReg <= '0;
    end else if ((state == S_DONE) && (op == LOAD)) begin
      holdReg <= ram_q;
    end
  end

  // Output decode: load data bypasses the hold register in its DONE cycle.
  always_comb begin
    rdata = holdReg;
    if ((state == S_DONE) && (op == LOAD)) begin
      rdata = ram_q;
    end
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign err      = errReg;
  assign ram_addr = addrLatch;
  assign ram_data = dataLatch;
  assign ram_we   = (state == S_ACCESS) && (op == STORE);

endmodule
